// File: rtl/req_arb4.sv
// Four-requester round-robin arbiter with a shared word mux and one-hot completion pulses.
// Optional stall timeout that revokes a grant is enabled by defining ARB_TIMEOUT_EN.
module req_arb4 #(
    parameter int W   = 32,
    parameter int TMO = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [W-1:0] din0,
    input  logic [W-1:0] din1,
    input  logic [W-1:0] din2,
    input  logic [W-1:0] din3,
    input  logic         ready,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [3:0]   done,
    output logic         tmo
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [1:0]   sel_q, sel_d;
    logic [1:0]   ptr_q, ptr_d;
    logic         xfer, abandon, timeout;
    logic [3:0]   cand;
    logic [1:0]   base, win, idx;
    logic         found;
    logic [W-1:0] din_arr [4];

    assign valid   = (state_q == S_BUSY);
    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign xfer    = valid & ready;
    assign abandon = valid & ~ready & ~req[sel_q];
    assign done    = gnt_q & {4{xfer}};

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;
    assign dout = valid ? din_arr[sel_q] : '0;

    // When a transfer completes, the finished requester is masked and the search starts just past it.
    always_comb begin
        cand  = valid ? (req & ~gnt_q) : req;
        base  = valid ? (sel_q + 2'd1) : ptr_q;
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (!valid) begin
            if (found) begin
                state_d = S_BUSY;
                gnt_d   = 4'b0001 << win;
                sel_d   = win;
            end
        end else if (xfer) begin
            ptr_d = sel_q + 2'd1;
            if (found) begin
                gnt_d = 4'b0001 << win;
                sel_d = win;
            end else begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                sel_d   = 2'd0;
            end
        end else if (abandon || timeout) begin
            ptr_d   = sel_q + 2'd1;
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            sel_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;
    logic          tmo_q;

    // Counter holds the number of stall cycles already spent; revoke on the TMO-th.
    assign stall   = valid & ~ready & req[sel_q];
    assign timeout = stall & (cnt_q == CW'(TMO - 1));
    assign cnt_d   = (stall && !timeout) ? cnt_q + 1'b1 : '0;
    assign tmo     = tmo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= timeout;
        end
    end
`else
    logic unused_tmo_cfg;

    assign timeout        = 1'b0;
    assign tmo            = 1'b0;
    assign unused_tmo_cfg = (TMO > 0);
`endif

endmodule

// File: tb/tb_req_arb4.sv
// Directed bench for req_arb4: reset, rotation, stalls, abandon, async reset, timeout.
module tb_req_arb4;
    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din0, din1, din2, din3;
    logic        ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        valid;
    logic [31:0] dout;
    logic [3:0]  done;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    req_arb4 #(.W(32), .TMO(15)) dut (
        .clk(clk), .reset(reset), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .ready(ready), .gnt(gnt), .sel(sel), .valid(valid),
        .dout(dout), .done(done), .tmo(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_busy(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic [31:0] d, input logic [3:0] dn);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".dout"}, dout, d);
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".sel"}, 32'(sel), 32'd0);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".dout"}, dout, 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b1111;
        ready = 1'b1;
        din0  = 32'hA0A0_0000;
        din1  = 32'hB1B1_1111;
        din2  = 32'hDEADBEEF;
        din3  = 32'hD3D3_3333;

        // Reset held with every requester active
        #1;
        chk_idle("rst_t0");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("rst_hold");
            chk("rst_hold.tmo", 32'(tmo), 32'd0);
        end

        // Single requester 2, immediate transfer
        reset = 1'b1;
        req   = 4'b0100;
        tick();
        chk_busy("single2", 4'b0100, 2'd2, 32'hDEADBEEF, 4'b0100);
        req = 4'b0000;
        tick();
        chk_idle("single2_idle");

        // Rotation from ptr=0 with all requesting
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
        tick();
        chk_busy("rot0", 4'b0001, 2'd0, din0, 4'b0001);
        tick();
        chk_busy("rot1", 4'b0010, 2'd1, din1, 4'b0010);
        tick();
        chk_busy("rot2", 4'b0100, 2'd2, din2, 4'b0100);
        tick();
        chk_busy("rot3", 4'b1000, 2'd3, din3, 4'b1000);
        tick();
        chk_busy("rot4", 4'b0001, 2'd0, din0, 4'b0001);
        req = 4'b0000;
        tick();
        chk_idle("rot_end");

        // Stall on requester 1 (ptr=1), others toggle meanwhile
        req   = 4'b0010;
        ready = 1'b0;
        tick();
        chk_busy("stall_s0", 4'b0010, 2'd1, din1, 4'b0000);
        req = 4'b1011;
        for (int i = 1; i < 10; i++) begin
            tick();
            chk_busy("stall_hold", 4'b0010, 2'd1, din1, 4'b0000);
        end
        ready = 1'b1;
        #1;
        chk("stall_done", 32'(done), 32'(4'b0010));
        // Back-to-back: from base 2, requester 3 wins over 0
        req = 4'b1001;
        tick();
        chk_busy("b2b", 4'b1000, 2'd3, din3, 4'b1000);
        req = 4'b0000;
        tick();
        chk_idle("b2b_idle");

        // Abandon of requester 2 (ptr=0), pointer moves to 3
        req   = 4'b0100;
        ready = 1'b0;
        tick();
        chk_busy("abn_grant", 4'b0100, 2'd2, din2, 4'b0000);
        req = 4'b0000;
        #1;
        chk("abn_done", 32'(done), 32'd0);
        tick();
        chk_idle("abn_idle");
        req = 4'b1001;
        tick();
        chk_busy("abn_ptr", 4'b1000, 2'd3, din3, 4'b0000);

        // Completed requester re-requests: one idle cycle, then granted again
        req   = 4'b1000;
        ready = 1'b1;
        #1;
        chk("rereq_done", 32'(done), 32'(4'b1000));
        tick();
        chk_idle("rereq_gap");
        ready = 1'b0;
        tick();
        chk_busy("rereq_again", 4'b1000, 2'd3, din3, 4'b0000);

        // Asynchronous reset between edges while busy
        #3;
        reset = 1'b0;
        ready = 1'b1;
        #1;
        chk_idle("async_rst");
        tick();
        chk_idle("async_rst_hold");
        reset = 1'b1;
        req   = 4'b1001;
        ready = 1'b0;
        tick();
        chk_busy("post_rst", 4'b0001, 2'd0, din0, 4'b0000);

`ifdef ARB_TIMEOUT_EN
        // Grant visible 15 cycles, then revoked with a tmo pulse
        for (int i = 1; i < 15; i++) begin
            tick();
            chk_busy("tmo_hold", 4'b0001, 2'd0, din0, 4'b0000);
            chk("tmo_hold.tmo", 32'(tmo), 32'd0);
        end
        tick();
        chk_idle("tmo_revoke");
        chk("tmo_pulse", 32'(tmo), 32'd1);
        tick();
        chk_busy("tmo_next", 4'b1000, 2'd3, din3, 4'b0000);
        chk("tmo_next.tmo", 32'(tmo), 32'd0);
`else
        // No timeout: grant held well past TMO, tmo stays low
        for (int i = 1; i < 20; i++) begin
            tick();
            chk_busy("notmo_hold", 4'b0001, 2'd0, din0, 4'b0000);
            chk("notmo.tmo", 32'(tmo), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
